// File: rtl/mem_delay_var.sv
// mem_delay_var
//   Runtime-programmable sample delay line. Each enabled sample is written
//   into a circular RAM. The sample written D enabled edges earlier is read
//   back from (wr_ptr - D). The active delay D can be reloaded at runtime
//   without flushing the buffer. out_stb stays low until the buffer again
//   holds D samples written under the current delay.
//
// Ports
//   clk       system clock, rising edge
//   aclr      asynchronous active-high reset
//   clk_en    sample enable; one sample accepted per enabled edge
//   in_data   input sample [WIDTH]
//   del_len   requested delay in enabled samples [ADDR_W]; 0 is treated as 1
//   del_load  single-cycle strobe that loads del_len into the active delay
//   out_data  registered delayed sample [WIDTH]
//   out_stb   registered; high for one clk on each edge that produced a valid sample
//   cur_del   currently active delay D [ADDR_W]

module mem_delay_var #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int DEF_DEL = 10
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              clk_en,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [ADDR_W-1:0] del_len,
    input  logic              del_load,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_stb,
    output logic [ADDR_W-1:0] cur_del
);

    localparam int               DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DEF_D   = ADDR_W'(DEF_DEL);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] rd_addr;
    logic              fill_ok;

    // Modulo-2^ADDR_W subtraction; D >= 1 keeps rd_addr away from wr_ptr.
    assign rd_addr = wr_ptr - cur_del;
    assign fill_ok = (fill >= cur_del);

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr   <= '0;
            fill     <= '0;
            cur_del  <= DEF_D;
            out_data <= '0;
            out_stb  <= 1'b0;
        end else begin
            // Write and pointer advance happen on any enabled edge, load or not.
            if (clk_en) begin
                wr_ptr <= wr_ptr + ONE;
            end

            if (del_load) begin
                // Restart the fill count so no output is qualified until D
                // samples exist under the new alignment.
                cur_del <= (del_len == '0) ? ONE : del_len;
                fill    <= '0;
                out_stb <= 1'b0;
                if (clk_en) begin
                    out_data <= '0;
                end
            end else if (clk_en) begin
                // Read-before-write: mem[rd_addr] sees pre-edge contents.
                out_stb  <= fill_ok;
                out_data <= fill_ok ? mem[rd_addr] : '0;
                if (fill != FILL_MAX) begin
                    fill <= fill + ONE;
                end
            end else begin
                out_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_delay_var.sv
// tb_mem_delay_var
//   Randomized and directed stimulus against a history-based reference model:
//   every enabled sample is appended to a queue, and a valid output is the
//   entry D positions back, once D samples have arrived since reset/load.

module tb_mem_delay_var;

    localparam int WIDTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int DEF_DEL = 10;

    logic              clk;
    logic              aclr;
    logic              clk_en;
    logic [WIDTH-1:0]  in_data;
    logic [ADDR_W-1:0] del_len;
    logic              del_load;
    logic [WIDTH-1:0]  out_data;
    logic              out_stb;
    logic [ADDR_W-1:0] cur_del;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [WIDTH-1:0] hist[$];
    int               since;
    int               d_m;
    logic [WIDTH-1:0] exp_out;
    logic             exp_stb;
    logic             out_known;

    mem_delay_var #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEF_DEL(DEF_DEL)
    ) dut (
        .clk     (clk),
        .aclr    (aclr),
        .clk_en  (clk_en),
        .in_data (in_data),
        .del_len (del_len),
        .del_load(del_load),
        .out_data(out_data),
        .out_stb (out_stb),
        .cur_del (cur_del)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        since     = 0;
        d_m       = DEF_DEL;
        exp_out   = '0;
        exp_stb   = 1'b0;
        out_known = 1'b1;
    endtask

    // Drive one clock edge and advance the reference model; outputs are
    // sampled 1 time unit after the rising edge by the calling test.
    task automatic do_edge(input logic en, input logic [WIDTH-1:0] data,
                           input logic load, input logic [ADDR_W-1:0] len);
        @(negedge clk);
        clk_en   = en;
        in_data  = data;
        del_load = load;
        del_len  = len;
        @(posedge clk);
        #1;
        if (load) begin
            d_m     = (len == 0) ? 1 : int'(len);
            since   = 0;
            exp_stb = 1'b0;
            if (en) begin
                out_known = 1'b0;
                hist.push_back(data);
            end
        end else if (en) begin
            if (since >= d_m) begin
                exp_out = hist[hist.size() - d_m];
                exp_stb = 1'b1;
            end else begin
                exp_out = '0;
                exp_stb = 1'b0;
            end
            out_known = 1'b1;
            hist.push_back(data);
            since++;
        end else begin
            exp_stb = 1'b0;
        end
        @(negedge clk);
        clk_en   = 1'b0;
        del_load = 1'b0;
    endtask

    task automatic test_reset();
        aclr     = 1'b1;
        clk_en   = 1'b0;
        in_data  = '0;
        del_len  = '0;
        del_load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (out_data !== '0 || out_stb !== 1'b0 || cur_del !== 4'(DEF_DEL)) begin
            errors++;
            $display("FAIL reset: out_data=%0h out_stb=%0b cur_del=%0d required 0/0/%0d",
                     out_data, out_stb, cur_del, DEF_DEL);
        end
        @(negedge clk);
        aclr = 1'b0;
        model_reset();
    endtask

    // Continuous stream 1,2,3,...: independent closed-form expectation.
    task automatic test_continuous(input string name, input int n);
        logic [WIDTH-1:0] want;
        for (int k = 1; k <= n; k++) begin
            do_edge(1'b1, WIDTH'(k), 1'b0, '0);
            want = (k > DEF_DEL) ? WIDTH'(k - DEF_DEL) : '0;
            checks++;
            if (out_stb !== (k > DEF_DEL) || out_data !== want) begin
                errors++;
                $display("FAIL %s edge %0d: out_data=%0d out_stb=%0b required %0d/%0b",
                         name, k, out_data, out_stb, want, (k > DEF_DEL));
            end
        end
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] last;
        for (int k = 0; k < 40; k++) begin
            last = out_data;
            do_edge(k[0] == 1'b0, WIDTH'(100 + k), 1'b0, '0);
            checks++;
            if (out_stb !== exp_stb || out_data !== exp_out) begin
                errors++;
                $display("FAIL gaps step %0d: out_data=%0d out_stb=%0b required %0d/%0b",
                         k, out_data, out_stb, exp_out, exp_stb);
            end
            if (k[0] == 1'b1) begin
                checks++;
                if (out_data !== last || out_stb !== 1'b0) begin
                    errors++;
                    $display("FAIL gaps_hold step %0d: out_data=%0d out_stb=%0b required %0d/0",
                             k, out_data, out_stb, last);
                end
            end
        end
    endtask

    task automatic test_load(input string name, input logic [ADDR_W-1:0] len,
                             input int want_d, input int n);
        do_edge(1'b1, WIDTH'($urandom), 1'b1, len);
        checks++;
        if (out_stb !== 1'b0 || cur_del !== ADDR_W'(want_d)) begin
            errors++;
            $display("FAIL %s load edge: out_stb=%0b cur_del=%0d required 0/%0d",
                     name, out_stb, cur_del, want_d);
        end
        for (int k = 1; k <= n; k++) begin
            do_edge(1'b1, WIDTH'($urandom), 1'b0, '0);
            checks++;
            if (out_stb !== (k > want_d) || out_stb !== exp_stb
                || out_data !== exp_out || cur_del !== ADDR_W'(want_d)) begin
                errors++;
                $display("FAIL %s edge %0d: out_data=%0h out_stb=%0b cur_del=%0d required %0h/%0b/%0d",
                         name, k, out_data, out_stb, cur_del, exp_out, exp_stb, want_d);
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        // make sure valid output is streaming with a non-default delay
        for (k = 0; k < 20; k++) do_edge(1'b1, WIDTH'($urandom), 1'b0, '0);
        checks++;
        if (out_stb !== 1'b1 || cur_del === 4'(DEF_DEL)) begin
            errors++;
            $display("FAIL pre_areset: out_stb=%0b cur_del=%0d required 1/not %0d",
                     out_stb, cur_del, DEF_DEL);
        end
        @(posedge clk);
        #3;
        aclr = 1'b1;
        #1;
        checks++;
        if (out_data !== '0 || out_stb !== 1'b0 || cur_del !== 4'(DEF_DEL)) begin
            errors++;
            $display("FAIL async_reset: out_data=%0h out_stb=%0b cur_del=%0d required 0/0/%0d",
                     out_data, out_stb, cur_del, DEF_DEL);
        end
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
        model_reset();
        test_continuous("refill", 14);
    endtask

    task automatic test_random();
        logic             en;
        logic             ld;
        logic [ADDR_W-1:0] len;
        for (int k = 0; k < 300; k++) begin
            en  = ($urandom_range(3) != 0);
            ld  = ($urandom_range(40) == 0);
            len = ADDR_W'($urandom);
            do_edge(en, WIDTH'($urandom), ld, len);
            checks++;
            if (out_stb !== exp_stb || (out_known && out_data !== exp_out)
                || cur_del !== ADDR_W'(d_m)) begin
                errors++;
                $display("FAIL random step %0d: out_data=%0h out_stb=%0b cur_del=%0d required %0h/%0b/%0d",
                         k, out_data, out_stb, cur_del, exp_out, exp_stb, d_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous("stream", 30);
        test_gaps();
        test_load("load3", 4'd3, 3, 12);
        test_load("load0", 4'd0, 1, 8);
        test_load("load_max", 4'd15, 15, 40);
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
